// File: rtl/imm_decode_ctrl.sv
// rtl/imm_decode_ctrl.sv - decode-stage immediate controller with two-entry skid buffer
//
// Accepts fetched instructions on a valid/ready handshake, decodes the opcode
// into Extender controls at push time and holds up to two decoded entries in
// FIFO order. The head entry drives the Extender and EX operand mux.
//
// Ports:
//   Clock, Reset_n             clock, asynchronous active-low reset
//   InstrIn, InValid, InReady  fetch side handshake (InReady depends on state only)
//   Flush                      synchronous flush, empties the buffer
//   OutValid, OutReady         EX side handshake for the head entry
//   Imm, SignExtImm, LuiSel,
//   ImmUsed, Illegal           decoded head entry fields
//   IllegalCount               saturating count of accepted illegal opcodes

module imm_decode_ctrl #(
    parameter int CNT_W = 8
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic [31:0]      InstrIn,
    input  logic             InValid,
    output logic             InReady,
    input  logic             Flush,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [15:0]      Imm,
    output logic             SignExtImm,
    output logic             LuiSel,
    output logic             ImmUsed,
    output logic             Illegal,
    output logic [CNT_W-1:0] IllegalCount
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    typedef struct packed {
        logic [15:0] imm;
        logic        sign;
        logic        lui;
        logic        used;
        logic        ill;
    } entry_t;

    state_t state, stateNext;
    entry_t headEntry, tailEntry, newEntry;
    logic   push, pop;

    // Only the opcode and immediate field matter to this stage.
    logic unusedBits;
    assign unusedBits = ^InstrIn[25:16];

    assign InReady  = (state != TWO);
    assign OutValid = (state != EMPTY);
    assign push     = InValid & InReady;
    assign pop      = OutValid & OutReady;

    assign Imm        = headEntry.imm;
    assign SignExtImm = headEntry.sign;
    assign LuiSel     = headEntry.lui;
    assign ImmUsed    = headEntry.used;
    assign Illegal    = headEntry.ill;

    always_comb begin
        newEntry      = '0;
        newEntry.imm  = InstrIn[15:0];
        case (InstrIn[31:26])
            6'b000000: ;
            6'b000100, 6'b000101, 6'b001001, 6'b001010,
            6'b001011, 6'b100011, 6'b101011: begin
                newEntry.used = 1'b1;
                newEntry.sign = 1'b1;
            end
            6'b001100, 6'b001101, 6'b001110: begin
                newEntry.used = 1'b1;
            end
            6'b001111: begin
                newEntry.used = 1'b1;
                newEntry.lui  = 1'b1;
            end
            default: newEntry.ill = 1'b1;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= EMPTY;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        if (Flush) begin
            stateNext = EMPTY;
        end else begin
            case (state)
                EMPTY:   if (push) stateNext = ONE;
                ONE: begin
                    if (push && !pop)      stateNext = TWO;
                    else if (pop && !push) stateNext = EMPTY;
                end
                TWO:     if (pop) stateNext = ONE;
                default: stateNext = EMPTY;
            endcase
        end
    end

    // The head is always slot 0; a pop in TWO shifts the tail forward, and a
    // simultaneous push/pop in ONE writes the new entry straight into the head.
    // A flush only moves the state; stale entry contents are don't-care.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            headEntry <= '0;
            tailEntry <= '0;
        end else if (!Flush) begin
            case (state)
                EMPTY: if (push) headEntry <= newEntry;
                ONE: begin
                    if (push && pop) headEntry <= newEntry;
                    else if (push)   tailEntry <= newEntry;
                end
                TWO:   if (pop) headEntry <= tailEntry;
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            IllegalCount <= '0;
        end else if (push && !Flush && newEntry.ill && (IllegalCount != {CNT_W{1'b1}})) begin
            IllegalCount <= IllegalCount + 1'b1;
        end
    end

endmodule

// File: tb/tb_imm_decode_ctrl.sv
// tb/tb_imm_decode_ctrl.sv - scoreboard testbench for imm_decode_ctrl

module tb_imm_decode_ctrl;

    logic        Clock;
    logic        Reset_n;
    logic [31:0] InstrIn;
    logic        InValid;
    logic        InReady;
    logic        Flush;
    logic        OutValid;
    logic        OutReady;
    logic [15:0] Imm;
    logic        SignExtImm;
    logic        LuiSel;
    logic        ImmUsed;
    logic        Illegal;
    logic [7:0]  IllegalCount;

    imm_decode_ctrl #(.CNT_W(8)) dut (
        .Clock(Clock), .Reset_n(Reset_n), .InstrIn(InstrIn), .InValid(InValid),
        .InReady(InReady), .Flush(Flush), .OutValid(OutValid), .OutReady(OutReady),
        .Imm(Imm), .SignExtImm(SignExtImm), .LuiSel(LuiSel), .ImmUsed(ImmUsed),
        .Illegal(Illegal), .IllegalCount(IllegalCount)
    );

    typedef struct {
        logic [31:0] instr;
        logic [15:0] imm;
        logic        sign;
        logic        lui;
        logic        used;
        logic        ill;
        logic [31:0] ext;
    } vec_t;

    // Hand-decoded vectors.
    localparam int ADDIU = 0, ORI = 1, LUI = 2, RTYPE = 3, BEQ = 4, LW = 5, SW = 6,
                   ANDI = 7, XORI = 8, SLTI = 9, SLTIU = 10, BNE = 11, BAD = 12, ADDI = 13;
    vec_t vecs [14];

    vec_t sb[$];
    vec_t curExp;
    int   nVec = 0;
    int   nErr = 0;
    int   pushes = 0;
    int   pops = 0;

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] extOut();
        if (LuiSel)          return {Imm, 16'h0000};
        else if (SignExtImm) return {{16{Imm[15]}}, Imm};
        else                 return {16'h0000, Imm};
    endfunction

    // Scoreboard monitor: records accepted beats and checks every pop in order.
    always @(negedge Clock) begin
        if (Reset_n) begin
            if (OutValid && OutReady && !Flush) begin
                pops++;
                if (sb.size() == 0) begin
                    check("sb_underflow", 32'd1, 32'd0);
                end else begin
                    vec_t e;
                    e = sb.pop_front();
                    check("imm",     {16'h0, Imm},      {16'h0, e.imm});
                    check("sign",    {31'h0, SignExtImm}, {31'h0, e.sign});
                    check("lui",     {31'h0, LuiSel},   {31'h0, e.lui});
                    check("immused", {31'h0, ImmUsed},  {31'h0, e.used});
                    check("illegal", {31'h0, Illegal},  {31'h0, e.ill});
                    check("ext",     extOut(),          e.ext);
                end
            end
            if (Flush) begin
                sb.delete();
            end else if (InValid && InReady) begin
                pushes++;
                sb.push_back(curExp);
            end
        end
    end

    task automatic cycle();
        @(posedge Clock);
        #1;
    endtask

    task automatic drive(input int idx);
        InstrIn = vecs[idx].instr;
        curExp  = vecs[idx];
        InValid = 1'b1;
    endtask

    task automatic waitAccept();
        bit done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge Clock);
            if (InReady && !Flush) done = 1;
            cycle();
        end
        if (!done) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic sendBeat(input int idx);
        drive(idx);
        waitAccept();
    endtask

    task automatic idle(input int n);
        InValid = 1'b0;
        repeat (n) cycle();
    endtask

    task automatic setVec(input int i, input logic [31:0] instr, input logic s, input logic l,
                          input logic u, input logic il, input logic [31:0] ext);
        vecs[i].instr = instr;
        vecs[i].imm   = instr[15:0];
        vecs[i].sign  = s;
        vecs[i].lui   = l;
        vecs[i].used  = u;
        vecs[i].ill   = il;
        vecs[i].ext   = ext;
    endtask

    initial begin
        setVec(ADDIU, 32'h2408_8EB7, 1, 0, 1, 0, 32'hFFFF_8EB7);
        setVec(ORI,   32'h3508_8EB7, 0, 0, 1, 0, 32'h0000_8EB7);
        setVec(LUI,   32'h3C08_1234, 0, 1, 1, 0, 32'h1234_0000);
        setVec(RTYPE, 32'h012A_4020, 0, 0, 0, 0, 32'h0000_4020);
        setVec(BEQ,   32'h1109_FFFC, 1, 0, 1, 0, 32'hFFFF_FFFC);
        setVec(LW,    32'h8D09_0004, 1, 0, 1, 0, 32'h0000_0004);
        setVec(SW,    32'hAD09_FFF0, 1, 0, 1, 0, 32'hFFFF_FFF0);
        setVec(ANDI,  32'h3108_F0F0, 0, 0, 1, 0, 32'h0000_F0F0);
        setVec(XORI,  32'h3908_8001, 0, 0, 1, 0, 32'h0000_8001);
        setVec(SLTI,  32'h2908_FFFF, 1, 0, 1, 0, 32'hFFFF_FFFF);
        setVec(SLTIU, 32'h2D08_7FFF, 1, 0, 1, 0, 32'h0000_7FFF);
        setVec(BNE,   32'h1509_8000, 1, 0, 1, 0, 32'hFFFF_8000);
        setVec(BAD,   32'hFC00_ABCD, 0, 0, 0, 1, 32'h0000_ABCD);
        setVec(ADDI,  32'h2000_1234, 0, 0, 0, 1, 32'h0000_1234);

        Reset_n  = 1'b0;
        InstrIn  = '0;
        InValid  = 1'b0;
        Flush    = 1'b0;
        OutReady = 1'b0;
        curExp   = vecs[0];
        #12;
        check("rst_outvalid", {31'h0, OutValid}, 32'd0);
        check("rst_inready",  {31'h0, InReady},  32'd1);
        check("rst_imm",      {16'h0, Imm},      32'd0);
        check("rst_flags",    {28'h0, SignExtImm, LuiSel, ImmUsed, Illegal}, 32'd0);
        check("rst_illcount", {24'h0, IllegalCount}, 32'd0);
        @(negedge Clock);
        Reset_n = 1'b1;
        cycle();

        // T1: single ADDIU, visible the cycle after the push edge
        OutReady = 1'b1;
        sendBeat(ADDIU);
        InValid = 1'b0;
        check("t1_outvalid", {31'h0, OutValid}, 32'd1);
        check("t1_ext",      extOut(), 32'hFFFF_8EB7);
        idle(2);

        // T2: stream covering the decode table, including ADDI which is illegal here
        sendBeat(ORI);   sendBeat(LUI);  sendBeat(RTYPE); sendBeat(BEQ);
        sendBeat(LW);    sendBeat(SW);   sendBeat(ANDI);  sendBeat(XORI);
        sendBeat(SLTI);  sendBeat(SLTIU); sendBeat(BNE);  sendBeat(ADDI);
        idle(3);
        check("t2_drained", {31'h0, OutValid}, 32'd0);
        check("t2_illcount", {24'h0, IllegalCount}, 32'd1);

        // T3: back-pressure, third beat held off until space frees
        OutReady = 1'b0;
        sendBeat(ORI);
        sendBeat(LUI);
        check("t3_full_inready", {31'h0, InReady}, 32'd0);
        drive(SW);
        repeat (3) cycle();
        check("t3_held_inready", {31'h0, InReady}, 32'd0);
        check("t3_head_held", {16'h0, Imm}, 32'h0000_8EB7);
        OutReady = 1'b1;
        waitAccept();
        idle(3);
        check("t3_sb_empty", sb.size(), 32'd0);
        check("t3_push_pop", pops, pushes);

        // T4: ONE with push and pop together
        OutReady = 1'b0;
        sendBeat(RTYPE);
        drive(ANDI);
        OutReady = 1'b1;
        cycle();
        InValid = 1'b0;
        check("t4_inready",  {31'h0, InReady},  32'd1);
        check("t4_outvalid", {31'h0, OutValid}, 32'd1);
        check("t4_head",     {16'h0, Imm},      32'h0000_F0F0);
        idle(3);

        // T5: flush in TWO with InValid high, then flush in ONE with an illegal push
        OutReady = 1'b0;
        sendBeat(BEQ);
        sendBeat(LW);
        drive(BAD);
        Flush = 1'b1;
        cycle();
        Flush = 1'b0;
        InValid = 1'b0;
        check("t5_outvalid", {31'h0, OutValid}, 32'd0);
        check("t5_inready",  {31'h0, InReady},  32'd1);
        sendBeat(SW);
        drive(BAD);
        OutReady = 1'b1;
        Flush = 1'b1;
        cycle();
        Flush = 1'b0;
        InValid = 1'b0;
        check("t5b_outvalid", {31'h0, OutValid}, 32'd0);
        check("t5_illcount",  {24'h0, IllegalCount}, 32'd1);
        idle(3);
        check("t5_sb_empty", sb.size(), 32'd0);

        // T6: saturate the illegal counter, then reset mid-stream
        OutReady = 1'b1;
        for (int i = 0; i < 260; i++) sendBeat(BAD);
        check("t6_illcount", {24'h0, IllegalCount}, 32'd255);
        @(negedge Clock);
        #2;
        Reset_n = 1'b0;
        sb.delete();
        #1;
        check("t6_rst_outvalid", {31'h0, OutValid}, 32'd0);
        check("t6_rst_illcount", {24'h0, IllegalCount}, 32'd0);
        check("t6_rst_inready",  {31'h0, InReady}, 32'd1);
        InValid = 1'b0;
        @(negedge Clock);
        Reset_n = 1'b1;
        cycle();
        sendBeat(LUI);
        InValid = 1'b0;
        idle(3);
        check("t6_final_sb", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
